// File: rtl/adc_stream_pkg.sv
// adc_stream_pkg: shared constants, FSM state type and sizing helper for the ADC packet stream.
package adc_stream_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   typedef enum logic [1:0] {IDLE, SYNC, SEQ, PAYLOAD} pktz_state_t;
   function automatic int bytes_per_ch(int w);
      return (w + 7) / 8;
   endfunction
endpackage

// File: rtl/adc_sample_packetizer.sv
// adc_sample_packetizer: frames ADC sample sets into sync/seq/payload byte packets on AXI-Stream.
module adc_sample_packetizer
   import adc_stream_pkg::*;
#(
   parameter int NUM_CHANNELS   = 2,
   parameter int SAMPLE_WIDTH   = 12,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                                 sys_clk,
   input  logic                                 sys_rst_n,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
   input  logic                                 sample_valid,
   output logic                                 sample_ready,
   input  logic                                 test_mode,
   output logic [7:0]                           m_tdata,
   output logic                                 m_tvalid,
   input  logic                                 m_tready,
   output logic                                 m_tlast,
   output logic [DROP_CNT_WIDTH-1:0]            drop_count
);
   localparam int BPC       = bytes_per_ch(SAMPLE_WIDTH);
   localparam int NPAY      = NUM_CHANNELS * BPC;
   localparam int PKT_BYTES = 2 + NPAY;
   localparam int IW        = $clog2(PKT_BYTES);
   localparam logic [IW-1:0] LAST = IW'(NPAY - 1);
   pktz_state_t             state;
   logic [NPAY*8-1:0]       hold, cap;
   logic [SAMPLE_WIDTH-1:0] pattern;
   logic [7:0]              seq, byte_nxt;
   logic [IW-1:0]           idx, idx_n;
   logic                    is_test;
   // Each channel lands in its own zero-padded little-endian byte slot.
   always_comb begin
      cap = '0;
      for (int k = 0; k < NUM_CHANNELS; k++)
         cap[k*BPC*8 +: SAMPLE_WIDTH] = test_mode ? SAMPLE_WIDTH'(pattern + SAMPLE_WIDTH'(k))
                                                  : sample_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
   end
   assign idx_n    = idx + 1'b1;
   assign byte_nxt = hold[idx_n*8 +: 8];
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         sample_ready <= 1'b1;
         m_tvalid     <= 1'b0;
         m_tlast      <= 1'b0;
         m_tdata      <= '0;
         drop_count   <= '0;
         seq          <= '0;
         pattern      <= '0;
         hold         <= '0;
         idx          <= '0;
         is_test      <= 1'b0;
      end else begin
         if (sample_valid && !sample_ready && drop_count != '1) drop_count <= drop_count + 1'b1;
         case (state)
            IDLE: if (sample_valid) begin
               hold         <= cap;
               is_test      <= test_mode;
               sample_ready <= 1'b0;
               m_tvalid     <= 1'b1;
               m_tdata      <= SYNC_BYTE;
               state        <= SYNC;
            end
            SYNC: if (m_tready) begin
               m_tdata <= seq;
               state   <= SEQ;
            end
            SEQ: if (m_tready) begin
               idx     <= '0;
               m_tdata <= hold[7:0];
               m_tlast <= (NPAY == 1);
               state   <= PAYLOAD;
            end
            PAYLOAD: if (m_tready) begin
               if (idx == LAST) begin
                  seq          <= seq + 1'b1;
                  pattern      <= is_test ? pattern + 1'b1 : pattern;
                  m_tvalid     <= 1'b0;
                  m_tlast      <= 1'b0;
                  m_tdata      <= '0;
                  sample_ready <= 1'b1;
                  state        <= IDLE;
               end else begin
                  idx     <= idx_n;
                  m_tdata <= byte_nxt;
                  m_tlast <= (idx_n == LAST);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_sample_packetizer.sv
// tb_adc_sample_packetizer: randomized and directed checks against a queue-based packet model.
module tb_adc_sample_packetizer;
   localparam int NC = 2;
   localparam int SW = 12;
   localparam int BPC = (SW + 7) / 8;
   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic [NC*SW-1:0] sample_data = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic          test_mode = 1'b0;
   logic [7:0]    m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic [15:0]   drop_count;
   int            n_checks = 0;
   int            n_fail = 0;
   logic [7:0]    byte_log[$];
   logic          last_log[$];
   adc_sample_packetizer #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .DROP_CNT_WIDTH(16)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_data(sample_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .test_mode(test_mode),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .drop_count(drop_count));
   always #5 sys_clk = ~sys_clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Behavioural model: a whole packet is expanded into a byte queue at acceptance.
   bit         m_busy = 0;
   logic [7:0] q[$];
   bit [7:0]   m_seq = 0;
   bit [SW-1:0] m_pat = 0;
   int         m_drops = 0;
   bit         m_test = 0;
   bit         prev_stall = 0;
   logic [8:0] prev_out = '0;
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         chk("rst_ready", sample_ready, 1);
         chk("rst_tvalid", m_tvalid, 0);
         chk("rst_tlast", m_tlast, 0);
         chk("rst_tdata", m_tdata, 0);
         chk("rst_drops", drop_count, 0);
         m_busy = 0; q.delete(); m_seq = 0; m_pat = 0; m_drops = 0; m_test = 0; prev_stall = 0;
      end else begin
         bit was_busy;
         chk("ready", sample_ready, !m_busy);
         chk("tvalid", m_tvalid, m_busy);
         chk("drops", drop_count, m_drops);
         if (m_busy) begin
            chk("tdata", m_tdata, q[0]);
            chk("tlast", m_tlast, q.size() == 1);
         end
         if (prev_stall) chk("stall_stable", {m_tlast, m_tdata}, prev_out);
         prev_stall = m_tvalid && !m_tready;
         prev_out = {m_tlast, m_tdata};
         if (m_tvalid && m_tready) begin
            byte_log.push_back(m_tdata);
            last_log.push_back(m_tlast);
         end
         was_busy = m_busy;
         if (was_busy && sample_valid && m_drops < 65535) m_drops++;
         if (was_busy && m_tready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_busy = 0;
               m_seq++;
               if (m_test) m_pat++;
            end
         end else if (!was_busy && sample_valid) begin
            m_busy = 1;
            m_test = test_mode;
            q.push_back(8'hA5);
            q.push_back(m_seq);
            for (int k = 0; k < NC; k++) begin
               int unsigned v;
               v = test_mode ? (int'(m_pat) + k) % (1 << SW) : int'(sample_data[k*SW +: SW]);
               for (int b = 0; b < BPC; b++) q.push_back(8'((v >> (8 * b)) & 255));
            end
         end
      end
   end
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask
   task automatic do_reset();
      sys_rst_n = 1'b0;
      tick(); tick();
      sys_rst_n = 1'b1;
      tick();
      byte_log.delete(); last_log.delete();
   endtask
   task automatic send(input logic [NC*SW-1:0] d);
      int b = 0;
      while (!sample_ready && b < 1000) begin tick(); b++; end
      if (b >= 1000) chk("send_timeout", 1, 0);
      sample_valid = 1'b1;
      sample_data = d;
      tick();
      sample_valid = 1'b0;
   endtask
   task automatic wait_bytes(input int n);
      int b = 0;
      while (byte_log.size() < n && b < 5000) begin tick(); b++; end
      if (byte_log.size() < n) chk("bytes_timeout", byte_log.size(), n);
   endtask
   task automatic chk_pkt6(input string name, input logic [47:0] exp);
      wait_bytes(6);
      for (int i = 0; i < 6; i++) begin
         chk({name, "_byte"}, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp[8*(5-i) +: 8]);
         chk({name, "_last"}, (last_log.size() > i) ? last_log[i] : 1'bx, i == 5);
      end
   endtask
   initial begin
      logic [7:0] exp5[12];
      exp5 = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
      do_reset();
      // Single packet, tready held high
      m_tready = 1'b1;
      send({12'hABC, 12'h123});
      chk_pkt6("t1", 48'hA5_00_23_01_BC_0A);
      // Same packet under alternating backpressure
      do_reset();
      send({12'hABC, 12'h123});
      for (int i = 0; i < 40 && byte_log.size() < 6; i++) begin
         m_tready = ~m_tready;
         tick();
      end
      m_tready = 1'b1;
      chk_pkt6("t2", 48'hA5_00_23_01_BC_0A);
      // 257 back-to-back packets: sequence number wraps
      do_reset();
      for (int p = 0; p < 257; p++) send(24'($urandom));
      wait_bytes(257 * 6);
      chk("t3_seq0", byte_log[1], 8'h00);
      chk("t3_seq255", byte_log[255 * 6 + 1], 8'hFF);
      chk("t3_seq256", byte_log[256 * 6 + 1], 8'h00);
      // Drops while busy, saturation, held sample untouched
      do_reset();
      m_tready = 1'b0;
      send({12'h456, 12'h789});
      tick();
      sample_valid = 1'b1; sample_data = 24'hFFFFFF;
      tick();
      sample_valid = 1'b0;
      tick();
      chk("t4_drop1", drop_count, 16'd1);
      sample_valid = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      sample_valid = 1'b0;
      tick();
      chk("t4_sat", drop_count, 16'hFFFF);
      m_tready = 1'b1;
      chk_pkt6("t4", 48'hA5_00_89_07_56_04);
      // Test pattern mode
      do_reset();
      test_mode = 1'b1;
      for (int p = 0; p < 3; p++) send(24'($urandom));
      test_mode = 1'b0;
      wait_bytes(18);
      for (int p = 0; p < 3; p++)
         for (int j = 0; j < 4; j++) chk("t5_pattern", byte_log[6 * p + 2 + j], exp5[4 * p + j]);
      // Reset during a payload-byte stall
      byte_log.delete(); last_log.delete();
      send({12'h111, 12'h222});
      wait_bytes(3);
      m_tready = 1'b0;
      tick();
      sys_rst_n = 1'b0;
      #1;
      chk("t6_tvalid", m_tvalid, 0);
      tick();
      sys_rst_n = 1'b1;
      m_tready = 1'b1;
      tick();
      byte_log.delete(); last_log.delete();
      send({12'h0F0, 12'h00F});
      chk_pkt6("t6", 48'hA5_00_0F_00_F0_00);
      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         sample_valid = ($urandom % 4) == 0;
         sample_data = 24'($urandom);
         test_mode = $urandom % 2;
         m_tready = ($urandom % 3) != 0;
         tick();
      end
      sample_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
